// File: rtl/crossbar_tdm_input_stage.sv
// rtl/crossbar_tdm_input_stage.sv - per-port FIFOs feeding a TDM barrel-shifter crossbar
// Optional per-port occupancy output enabled by defining CROSSBAR_OCC_CNT_EN.
module crossbar_tdm_input_stage #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0][W-1:0]          in_data,
  input  logic [N-1:0]                 in_valid,
  output logic [N-1:0]                 in_ready,
  input  logic                         run,
  output logic [N-1:0][W-1:0]          sw_data,
  output logic [N-1:0]                 sw_valid,
  output logic [$clog2(N)-1:0]         sw_shift
`ifdef CROSSBAR_OCC_CNT_EN
  ,
  output logic [N-1:0][$clog2(DEPTH):0] occ
`endif
);

  localparam int SW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  logic [SW-1:0] slot;

  // Slot counter wraps at N-1 so non-power-of-2 port counts rotate correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      sw_shift <= '0;
    end else if (run) begin
      sw_shift <= slot;
      slot     <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_port
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [W-1:0]  data_q;
    logic          valid_q;
    logic          push;
    logic          pop;

    // Ready and pop both come from registered count: no bypass, no pass-through.
    assign in_ready[k] = (count != FULL_CNT);
    assign push        = in_valid[k] & in_ready[k];
    assign pop         = run & (count != '0);
    assign sw_data[k]  = data_q;
    assign sw_valid[k] = valid_q;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= pop;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          data_q <= mem[rd_ptr];
        end
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end

`ifdef CROSSBAR_OCC_CNT_EN
    assign occ[k] = count;
`endif
  end

endmodule
